// File: rtl/nios_mult_cell_pipe.sv
// nios_mult_cell_pipe: 3-stage pipelined WIDTHxWIDTH multiplier producing the selected half of the
// full 2*WIDTH product, with valid/ready backpressure and a pass-through tag.
module nios_mult_cell_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_a_sgn,
  input  logic             in_b_sgn,
  input  logic             in_hi,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int HALF = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;
  logic             stall;
  logic             v1, v2, v3;
  logic [WIDTH-1:0] ea_l, ea_h, eb_l, eb_h;
  logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic             s1_a_sgn, s1_b_sgn, s1_hi, s2_hi;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [W2-1:0]    sum_d, s2_sum;
  logic [WIDTH-1:0] res_d;
  function automatic logic [W2-1:0] ext(input logic [WIDTH-1:0] p, input logic s);
    return {{WIDTH{s & p[WIDTH-1]}}, p};
  endfunction
  assign stall     = v3 & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3;
  // Half operands widened to WIDTH so each HALFxHALF product is exact modulo 2^WIDTH.
  always_comb begin
    ea_l = {{HALF{1'b0}}, in_a[HALF-1:0]};
    eb_l = {{HALF{1'b0}}, in_b[HALF-1:0]};
    ea_h = {{HALF{in_a_sgn & in_a[WIDTH-1]}}, in_a[WIDTH-1:HALF]};
    eb_h = {{HALF{in_b_sgn & in_b[WIDTH-1]}}, in_b[WIDTH-1:HALF]};
  end
  always_comb begin
    sum_d = ext(pp_ll, 1'b0)
          + (ext(pp_lh, s1_b_sgn) << HALF)
          + (ext(pp_hl, s1_a_sgn) << HALF)
          + (ext(pp_hh, s1_a_sgn | s1_b_sgn) << WIDTH);
    res_d = s2_hi ? s2_sum[W2-1:WIDTH] : s2_sum[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {v1, v2, v3} <= '0;
      {pp_ll, pp_lh, pp_hl, pp_hh} <= '0;
      {s1_a_sgn, s1_b_sgn, s1_hi, s2_hi} <= '0;
      {s1_tag, s2_tag, out_tag} <= '0;
      s2_sum <= '0;
      out_result <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      pp_ll <= ea_l * eb_l;
      pp_lh <= ea_l * eb_h;
      pp_hl <= ea_h * eb_l;
      pp_hh <= ea_h * eb_h;
      s1_a_sgn <= in_a_sgn;
      s1_b_sgn <= in_b_sgn;
      s1_hi <= in_hi;
      s1_tag <= in_tag;
      s2_sum <= sum_d;
      s2_hi <= s1_hi;
      s2_tag <= s1_tag;
      out_result <= res_d;
      out_tag <= s2_tag;
    end
  end
endmodule

// File: tb/tb_nios_mult_cell_pipe.sv
// tb_nios_mult_cell_pipe: directed and randomized checks of the pipelined multiplier against a
// 64-bit arithmetic reference and an in-order expectation queue.
module tb_nios_mult_cell_pipe;
  logic        clk = 0, reset = 1, in_valid = 0, in_a_sgn = 0, in_b_sgn = 0, in_hi = 0, out_ready = 1;
  logic        in_ready, out_valid;
  logic [31:0] in_a = 0, in_b = 0, out_result;
  logic [4:0]  in_tag = 0, out_tag;
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] exp_res[$];
  logic [4:0]  exp_tag[$];
  logic [4:0]  log_tag[$];
  int          log_cyc[$];
  logic        hold_v = 0;
  logic [31:0] hold_r = 0;
  logic [4:0]  hold_t = 0;

  always #5 clk = ~clk;

  nios_mult_cell_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_a_sgn(in_a_sgn), .in_b_sgn(in_b_sgn), .in_hi(in_hi), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic as, input logic bs, input logic hi);
    logic [63:0] ea, eb, p;
    ea = as ? {{32{a[31]}}, a} : {32'b0, a};
    eb = bs ? {{32{b[31]}}, b} : {32'b0, b};
    p = ea * eb;
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0000;
      4: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op(input logic [4:0] tag);
    in_a = pick();
    in_b = pick();
    in_a_sgn = $urandom % 2;
    in_b_sgn = $urandom % 2;
    in_hi = $urandom % 2;
    in_tag = tag;
  endtask

  // Observes transfers just before each rising edge and checks them against the queue.
  always @(negedge clk) begin : mon
    logic [31:0] er;
    logic [4:0]  et;
    cyc++;
    chk(in_ready == !(out_valid && !out_ready), "in_ready", in_ready, !(out_valid && !out_ready));
    if (reset) begin
      exp_res.delete();
      exp_tag.delete();
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk(out_result == hold_r, "stall result stable", out_result, hold_r);
        chk(out_tag == hold_t, "stall tag stable", out_tag, hold_t);
      end
      if (out_valid && exp_res.size() == 0)
        chk(0, "spurious out_valid", out_tag, 0);
      else if (out_valid && out_ready) begin
        er = exp_res.pop_front();
        et = exp_tag.pop_front();
        chk(out_result == er, "result", out_result, er);
        chk(out_tag == et, "tag", out_tag, et);
        log_tag.push_back(out_tag);
        log_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        exp_res.push_back(model(in_a, in_b, in_a_sgn, in_b_sgn, in_hi));
        exp_tag.push_back(in_tag);
      end
      hold_v = out_valid && !out_ready;
      hold_r = out_result;
      hold_t = out_tag;
    end
  end

  task automatic one_op(input logic [31:0] a, input logic [31:0] b, input logic as, input logic bs,
                        input logic hi, input logic [4:0] tag, input logic [31:0] want, input string name);
    int n;
    step();
    out_ready = 1;
    in_valid = 1;
    in_a = a; in_b = b; in_a_sgn = as; in_b_sgn = bs; in_hi = hi; in_tag = tag;
    chk(model(a, b, as, bs, hi) == want, {name, " model"}, model(a, b, as, bs, hi), want);
    step();
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk(n == 3, {name, " latency"}, n, 3);
    chk(out_result == want, name, out_result, want);
    chk(out_tag == tag, {name, " tag"}, out_tag, tag);
  endtask

  task automatic drain();
    int c = 0;
    in_valid = 0;
    out_ready = 1;
    while (exp_res.size() > 0 && c < 200) begin
      step();
      c++;
    end
    chk(exp_res.size() == 0, "drain", exp_res.size(), 0);
  endtask

  task automatic stream(input int first, input int count, input int stall_at, input int stall_len);
    int sent = 0, c = 0;
    while (sent < count && c < 200) begin
      step();
      c++;
      out_ready = !(c >= stall_at && c < stall_at + stall_len);
      in_valid = 1;
      rand_op(5'(first + sent));
      #1;
      if (out_valid && !out_ready) chk(!in_ready, "in_ready during stall", in_ready, 0);
      if (in_ready) sent++;
    end
    step();
    drain();
  endtask

  initial begin
    repeat (3) step();
    reset = 0;
    chk(out_valid == 0, "reset out_valid", out_valid, 0);
    chk(out_result == 0, "reset out_result", out_result, 0);
    chk(out_tag == 0, "reset out_tag", out_tag, 0);
    chk(in_ready == 1, "reset in_ready", in_ready, 1);

    one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'h0000_0001, "uu lo");
    one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 2, 32'hFFFF_FFFE, "uu hi");
    one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 3, 32'h0000_0000, "ss hi");
    one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 4, 32'h0000_0001, "ss lo");
    one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 5, 32'hFFFF_FFFF, "su hi");
    one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 6, 32'h0000_0001, "su lo");
    one_op(32'h8000_0000, 32'h8000_0000, 1, 1, 1, 7, 32'h4000_0000, "min ss hi");
    one_op(32'h8000_0000, 32'h8000_0000, 1, 1, 0, 8, 32'h0000_0000, "min ss lo");
    one_op(32'h8000_0000, 32'h8000_0000, 0, 0, 1, 9, 32'h4000_0000, "min uu hi");
    one_op(32'h8000_0000, 32'h8000_0000, 0, 0, 0, 10, 32'h0000_0000, "min uu lo");
    one_op(32'h8000_0000, 32'h7FFF_FFFF, 1, 1, 1, 11, 32'hC000_0000, "min*max hi");
    one_op(32'h8000_0000, 32'h7FFF_FFFF, 1, 1, 0, 12, 32'h8000_0000, "min*max lo");
    one_op(32'h0000_0003, 32'hFFFF_FFFE, 0, 1, 0, 13, 32'hFFFF_FFFA, "us lo");
    drain();

    log_tag.delete();
    log_cyc.delete();
    stream(0, 8, 1000, 0);
    chk(log_tag.size() == 8, "stream count", log_tag.size(), 8);
    for (int i = 0; i < 8 && i < log_tag.size(); i++) begin
      chk(log_tag[i] == 5'(i), "stream order", log_tag[i], i);
      chk(log_cyc[i] == log_cyc[0] + i, "stream back-to-back", log_cyc[i] - log_cyc[0], i);
    end

    log_tag.delete();
    log_cyc.delete();
    stream(8, 8, 5, 4);
    chk(log_tag.size() == 8, "stall stream count", log_tag.size(), 8);
    for (int i = 0; i < 8 && i < log_tag.size(); i++)
      chk(log_tag[i] == 5'(i + 8), "stall stream order", log_tag[i], i + 8);

    step();
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      rand_op(5'(20 + i));
      step();
    end
    in_valid = 0;
    chk(out_valid == 1 && in_ready == 0, "stalled before reset", {out_valid, in_ready}, 2'b10);
    step();
    reset = 1;
    step();
    reset = 0;
    chk(out_valid == 0, "out_valid after reset", out_valid, 0);
    chk(in_ready == 1, "in_ready after reset", in_ready, 1);
    out_ready = 1;
    repeat (6) step();
    chk(out_valid == 0, "no stale result", out_valid, 0);
    one_op(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1, 30, 32'h0B00_EA4E, "after reset");
    drain();

    begin
      int sent = 0, c = 0;
      logic pend = 0;
      while (sent < 10000 && c < 60000) begin
        step();
        c++;
        out_ready = ($urandom % 4) != 0;
        if (!pend && ($urandom % 3) != 0) begin
          rand_op(5'($urandom));
          pend = 1;
        end
        in_valid = pend;
        #1;
        if (pend && in_ready) begin
          pend = 0;
          sent++;
        end
      end
      step();
      drain();
      chk(sent == 10000, "random ops issued", sent, 10000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
